// File: rtl/inst_queue_pkg.sv
// Shared definitions for the instruction queue: default sizes and slot-count helper.
package inst_queue_pkg;

   localparam int unsigned IQ_DEPTH_DEFAULT = 8;
   localparam int unsigned IQ_INST_W_DEFAULT = 32;
   localparam int unsigned IQ_PC_W_DEFAULT = 32;

   // Number of slots covered by a two-bit valid/take mask. Only 00, 01 and 11
   // are legal; 10 counts as zero so a malformed mask never moves a pointer.
   function automatic logic [1:0] slot_count(input logic [1:0] mask);
      logic [1:0] n;
      n = 2'd0;
      if (mask[0]) begin
         n = mask[1] ? 2'd2 : 2'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/inst_queue_ptr.sv
// Queue pointer advance by 0, 1 or 2; the extra MSB acts as the wrap bit.
module inst_queue_ptr #(
   parameter int unsigned PTR_W = 4
) (
   input  logic [PTR_W-1:0] ptr,
   input  logic [1:0]       inc,
   output logic [PTR_W-1:0] nxt
);

   // Natural modulo-2^PTR_W wrap keeps the wrap bit toggling every DEPTH entries.
   always_comb begin
      nxt = ptr + PTR_W'(inc);
   end

endmodule

// File: rtl/inst_queue.sv
// Two-wide instruction queue between IF and ID: circular buffer of {inst, pc, npc}.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = IQ_DEPTH_DEFAULT,
   parameter int unsigned INST_W = IQ_INST_W_DEFAULT,
   parameter int unsigned PC_W   = IQ_PC_W_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      stop,
   input  logic                      flush,
   input  logic [1:0]                in_valid,
   input  logic [INST_W-1:0]         in0_inst,
   input  logic [INST_W-1:0]         in1_inst,
   input  logic [PC_W-1:0]           in0_pc,
   input  logic [PC_W-1:0]           in1_pc,
   input  logic [PC_W-1:0]           in0_npc,
   input  logic [PC_W-1:0]           in1_npc,
   output logic                      in_ready,
   output logic [1:0]                out_valid,
   output logic [INST_W-1:0]         out0_inst,
   output logic [INST_W-1:0]         out1_inst,
   output logic [PC_W-1:0]           out0_pc,
   output logic [PC_W-1:0]           out1_pc,
   output logic [PC_W-1:0]           out0_npc,
   output logic [PC_W-1:0]           out1_npc,
   input  logic [1:0]                out_take,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      instbuf_full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   // Storage is deliberately left out of reset.
   logic [INST_W-1:0] mem_inst [DEPTH];
   logic [PC_W-1:0]   mem_pc   [DEPTH];
   logic [PC_W-1:0]   mem_npc  [DEPTH];

   logic [PW-1:0] wptr, wptr_nxt;
   logic [PW-1:0] rptr, rptr_nxt;
   logic [1:0]    push_n, pop_n;
   logic          push_en, pop_en;
   logic [AW-1:0] wr_idx0, wr_idx1;
   logic [AW-1:0] rd_idx0, rd_idx1;

   // Occupancy, readiness and head-valid flags, all from the current pointers.
   always_comb begin
      count        = wptr - rptr;
      in_ready     = (count <= PW'(DEPTH - 2));
      instbuf_full = !in_ready;
      out_valid[0] = (count != '0);
      out_valid[1] = (count >= PW'(2));
   end

   // Push/pop amounts; flush and stop gate both sides, take is masked by what is valid.
   always_comb begin
      push_en = in_ready && !stop && !flush;
      pop_en  = !stop && !flush;
      push_n  = push_en ? slot_count(in_valid) : 2'd0;
      pop_n   = pop_en ? slot_count(out_take & out_valid) : 2'd0;
   end

   inst_queue_ptr #(
      .PTR_W (PW)
   ) u_wptr (
      .ptr (wptr),
      .inc (push_n),
      .nxt (wptr_nxt)
   );

   inst_queue_ptr #(
      .PTR_W (PW)
   ) u_rptr (
      .ptr (rptr),
      .inc (pop_n),
      .nxt (rptr_nxt)
   );

   // Pointer state; flush returns both pointers to the origin.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         wptr <= wptr_nxt;
         rptr <= rptr_nxt;
      end
   end

   // Write/read slot indices; the second slot wraps within the array.
   always_comb begin
      wr_idx0 = wptr[AW-1:0];
      wr_idx1 = wr_idx0 + AW'(1);
      rd_idx0 = rptr[AW-1:0];
      rd_idx1 = rd_idx0 + AW'(1);
   end

   // Entry writes for the accepted slots, in slot order.
   always_ff @(posedge clk) begin
      if (push_n != 2'd0) begin
         mem_inst[wr_idx0] <= in0_inst;
         mem_pc[wr_idx0]   <= in0_pc;
         mem_npc[wr_idx0]  <= in0_npc;
      end
      if (push_n == 2'd2) begin
         mem_inst[wr_idx1] <= in1_inst;
         mem_pc[wr_idx1]   <= in1_pc;
         mem_npc[wr_idx1]  <= in1_npc;
      end
   end

   // Head and head+1 straight from storage; no path from the IF inputs.
   always_comb begin
      out0_inst = mem_inst[rd_idx0];
      out0_pc   = mem_pc[rd_idx0];
      out0_npc  = mem_npc[rd_idx0];
      out1_inst = mem_inst[rd_idx1];
      out1_pc   = mem_pc[rd_idx1];
      out1_npc  = mem_npc[rd_idx1];
   end

endmodule

// File: tb/tb_inst_queue.sv
// Directed, table-driven bench for inst_queue (DEPTH=8, 32-bit inst/pc).
module tb_inst_queue;

   logic        clk;
   logic        rst;
   logic        stop;
   logic        flush;
   logic [1:0]  in_valid;
   logic [31:0] in0_inst, in1_inst, in0_pc, in1_pc, in0_npc, in1_npc;
   logic        in_ready;
   logic [1:0]  out_valid;
   logic [31:0] out0_inst, out1_inst, out0_pc, out1_pc, out0_npc, out1_npc;
   logic [1:0]  out_take;
   logic [3:0]  count;
   logic        instbuf_full;

   int n_checks;
   int n_fail;

   inst_queue #(
      .DEPTH  (8),
      .INST_W (32),
      .PC_W   (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stop         (stop),
      .flush        (flush),
      .in_valid     (in_valid),
      .in0_inst     (in0_inst),
      .in1_inst     (in1_inst),
      .in0_pc       (in0_pc),
      .in1_pc       (in1_pc),
      .in0_npc      (in0_npc),
      .in1_npc      (in1_npc),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out0_inst    (out0_inst),
      .out1_inst    (out1_inst),
      .out0_pc      (out0_pc),
      .out1_pc      (out1_pc),
      .out0_npc     (out0_npc),
      .out1_npc     (out1_npc),
      .out_take     (out_take),
      .count        (count),
      .instbuf_full (instbuf_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stop;
      logic        flush;
      logic [1:0]  iv;
      logic [31:0] pc0;
      logic [31:0] pc1;
      logic [1:0]  take;
      logic [3:0]  e_cnt;
      logic [1:0]  e_ov;
      logic        e_rdy;
      logic        chk0;
      logic        chk1;
      logic [31:0] e_pc0;
      logic [31:0] e_pc1;
   } vec_t;

   localparam int NV = 13;
   vec_t vec [NV];

   function automatic logic [31:0] mk_inst(input logic [31:0] pc);
      return {pc[15:0], ~pc[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic f, input logic [1:0] iv,
                        input logic [31:0] p0, input logic [31:0] p1,
                        input logic [1:0] tk);
      stop     = s;
      flush    = f;
      in_valid = iv;
      in0_pc   = p0;
      in1_pc   = p1;
      in0_inst = mk_inst(p0);
      in1_inst = mk_inst(p1);
      in0_npc  = p0 + 32'd4;
      in1_npc  = p1 + 32'd4;
      out_take = tk;
   endtask

   task automatic check_state(input string tag, input logic [3:0] cnt, input logic [1:0] ov,
                              input logic rdy);
      check({tag, ".count"}, 32'(count), 32'(cnt));
      check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
      check({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
      check({tag, ".full"}, 32'(instbuf_full), 32'(!rdy));
   endtask

   task automatic check_head0(input string tag, input logic [31:0] pc);
      check({tag, ".out0_pc"}, out0_pc, pc);
      check({tag, ".out0_inst"}, out0_inst, mk_inst(pc));
      check({tag, ".out0_npc"}, out0_npc, pc + 32'd4);
   endtask

   task automatic check_head1(input string tag, input logic [31:0] pc);
      check({tag, ".out1_pc"}, out1_pc, pc);
      check({tag, ".out1_inst"}, out1_inst, mk_inst(pc));
      check({tag, ".out1_npc"}, out1_npc, pc + 32'd4);
   endtask

   initial begin
      logic [31:0] head, next_pc;
      n_checks = 0;
      n_fail   = 0;

      //            stop  flush iv     pc0        pc1        take  cnt   ov     rdy  c0 c1 e_pc0      e_pc1
      vec[0]  = '{1'b0, 1'b0, 2'b11, 32'h100, 32'h104, 2'b00, 4'd2, 2'b11, 1'b1, 1, 1, 32'h100, 32'h104};
      vec[1]  = '{1'b0, 1'b0, 2'b11, 32'h108, 32'h10C, 2'b00, 4'd4, 2'b11, 1'b1, 1, 1, 32'h100, 32'h104};
      vec[2]  = '{1'b0, 1'b0, 2'b11, 32'h110, 32'h114, 2'b00, 4'd6, 2'b11, 1'b1, 1, 1, 32'h100, 32'h104};
      vec[3]  = '{1'b0, 1'b0, 2'b11, 32'h118, 32'h11C, 2'b00, 4'd8, 2'b11, 1'b0, 1, 1, 32'h100, 32'h104};
      vec[4]  = '{1'b0, 1'b0, 2'b11, 32'h120, 32'h124, 2'b00, 4'd8, 2'b11, 1'b0, 1, 1, 32'h100, 32'h104};
      vec[5]  = '{1'b0, 1'b0, 2'b11, 32'h120, 32'h124, 2'b11, 4'd6, 2'b11, 1'b1, 1, 1, 32'h108, 32'h10C};
      vec[6]  = '{1'b0, 1'b0, 2'b00, 32'h0,   32'h0,   2'b01, 4'd5, 2'b11, 1'b1, 1, 1, 32'h10C, 32'h110};
      vec[7]  = '{1'b0, 1'b0, 2'b00, 32'h0,   32'h0,   2'b10, 4'd5, 2'b11, 1'b1, 1, 1, 32'h10C, 32'h110};
      vec[8]  = '{1'b1, 1'b0, 2'b11, 32'h500, 32'h504, 2'b11, 4'd5, 2'b11, 1'b1, 1, 1, 32'h10C, 32'h110};
      vec[9]  = '{1'b1, 1'b1, 2'b11, 32'h600, 32'h604, 2'b11, 4'd0, 2'b00, 1'b1, 0, 0, 32'h0,   32'h0};
      vec[10] = '{1'b0, 1'b0, 2'b01, 32'h200, 32'h0,   2'b00, 4'd1, 2'b01, 1'b1, 1, 0, 32'h200, 32'h0};
      vec[11] = '{1'b0, 1'b0, 2'b11, 32'h204, 32'h208, 2'b11, 4'd2, 2'b11, 1'b1, 1, 1, 32'h204, 32'h208};
      vec[12] = '{1'b0, 1'b0, 2'b01, 32'h20C, 32'h0,   2'b01, 4'd2, 2'b11, 1'b1, 1, 1, 32'h208, 32'h20C};

      // Reset state is visible while rst is still low.
      rst = 1'b0;
      drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00);
      #2;
      check_state("reset", 4'd0, 2'b00, 1'b1);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vec[i].stop, vec[i].flush, vec[i].iv, vec[i].pc0, vec[i].pc1, vec[i].take);
         if (vec[i].take == 2'b10) $display("note: protocol error out_take=10 applied (vec %0d)", i);
         #1;
         // Before the edge, nothing pushed this cycle may be visible yet.
         if (i == 0) check("vec0.no_bypass", 32'(out_valid), 32'(2'b00));
         @(posedge clk);
         #1;
         check_state($sformatf("vec%0d", i), vec[i].e_cnt, vec[i].e_ov, vec[i].e_rdy);
         if (vec[i].chk0) check_head0($sformatf("vec%0d", i), vec[i].e_pc0);
         if (vec[i].chk1) check_head1($sformatf("vec%0d", i), vec[i].e_pc1);
      end

      // Steady push 2 / take 2 across several pointer wraps.
      head    = 32'h208;
      next_pc = 32'h210;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         drive(1'b0, 1'b0, 2'b11, next_pc, next_pc + 32'd4, 2'b11);
         next_pc = next_pc + 32'd8;
         head    = head + 32'd8;
         @(posedge clk);
         #1;
         check($sformatf("wrap%0d.count", c), 32'(count), 32'd2);
         check($sformatf("wrap%0d.out0_pc", c), out0_pc, head);
         check($sformatf("wrap%0d.out1_pc", c), out1_pc, head + 32'd4);
      end

      // Prime count=3, then hold it under stop.
      @(negedge clk);
      drive(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00);
      @(negedge clk);
      drive(1'b0, 1'b0, 2'b11, 32'h300, 32'h304, 2'b00);
      @(negedge clk);
      drive(1'b0, 1'b0, 2'b01, 32'h308, 32'h0, 2'b00);
      @(posedge clk);
      #1;
      check_state("prime3", 4'd3, 2'b11, 1'b1);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         drive(1'b1, 1'b0, 2'b11, 32'h700, 32'h704, 2'b11);
         @(posedge clk);
         #1;
         check_state($sformatf("stop%0d", c), 4'd3, 2'b11, 1'b1);
         check_head0($sformatf("stop%0d", c), 32'h300);
         check_head1($sformatf("stop%0d", c), 32'h304);
      end

      // Asynchronous reset between edges, then a push on the first edge after release.
      drive(1'b0, 1'b0, 2'b11, 32'h400, 32'h404, 2'b00);
      #2;
      rst = 1'b0;
      #1;
      check_state("midrst", 4'd0, 2'b00, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_state("postrst", 4'd2, 2'b11, 1'b1);
      check_head0("postrst", 32'h400);
      check_head1("postrst", 32'h404);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 8, entry count; power of two, 4..64.
REQ-002 Parameter INST_W, default 32, instruction width.
REQ-003 Parameter PC_W, default 32, pc/npc width.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 stop  input  1  pipeline freeze; no push, no pop while high.
REQ-007 flush  input  1  branch redirect; discard all contents.
REQ-008 in_valid  input  2  IF slot valid; bit1 set only when bit0 set.
REQ-009 in0_inst/in1_inst  input  INST_W  IF slot instructions.
REQ-010 in0_pc/in1_pc, in0_npc/in1_npc  input  PC_W  slot pc and predicted next pc.
REQ-011 in_ready  output  1  high when free entries >= 2.
REQ-012 out_valid  output  2  head entries valid; bit1 implies bit0.
REQ-013 out0_inst/out1_inst, out0_pc/out1_pc, out0_npc/out1_npc  output  per above  head and head+1 entries.
REQ-014 out_take  input  2  ID consumption: 00 none, 01 one, 11 two; 10 illegal.
REQ-015 count  output  $clog2(DEPTH)+1  occupied entries.
REQ-016 instbuf_full  output  1  equals !in_ready.

Function
REQ-017 Circular storage of DEPTH entries {inst, pc, npc}; write/read pointers $clog2(DEPTH)+1 bits, MSB as wrap bit.
REQ-018 Push: when in_ready && !stop && !flush, write in_valid slots in order (slot0 at wptr, slot1 at wptr+1); wptr advances by popcount(in_valid).
REQ-019 in_ready derives from count at cycle start only; same-cycle pops do not raise it.
REQ-020 Push with in_ready low: inputs ignored, no state change from the write side.
REQ-021 out_valid[0] = count>=1, out_valid[1] = count>=2; outputs driven combinationally from rptr, rptr+1 (mod DEPTH).
REQ-022 Pop: when !stop && !flush, rptr advances by popcount(out_take & out_valid); take bits beyond out_valid ignored.
REQ-023 No input-to-output bypass: pushed entry visible on out ports one cycle after the push edge at earliest.
REQ-024 Simultaneous push and pop: count_next = count + pushed - popped.
REQ-025 flush: next edge sets rptr=wptr=0, count=0; flush overrides push, pop and stop.
REQ-026 stop without flush: pointers, count and storage hold.
REQ-027 Pointer wrap: index = pointer mod DEPTH; full when pointers differ only in MSB (count=DEPTH).
REQ-028 Empty (count=0): out_valid=00; out data don't-care but deterministic (stale entry).
REQ-029 out_take=10: treated as 00; bench flags as protocol error.

Reset
REQ-030 rst low: immediately rptr=0, wptr=0, count=0, out_valid=00, in_ready=1, instbuf_full=0.
REQ-031 Storage array not reset; out data unspecified until first push.
REQ-032 Reset mid-operation discards all entries; first edge after release accepts a push.

Structure
REQ-033 Shared header def.vh holds INST_BUS, PC_BUS width macros and default DEPTH; no new package.
REQ-034 Single module; optional sub-module iq_ptr (pointer increment-by-0/1/2 with wrap) instantiated twice.
REQ-035 Estimated size 150-250 lines RTL.

Verification
REQ-036 Reset, push 2 entries (pc 0x100, 0x104) -> next cycle out_valid=11, out0_pc=0x100, out1_pc=0x104, count=2.
REQ-037 DEPTH=8, push 2/cycle for 3 cycles, no take -> count=6, in_ready=1; fourth push -> count=8, in_ready=0, instbuf_full=1; fifth push ignored.
REQ-038 Count=8, take 11 with push 11 same cycle -> push ignored, count=6; next cycle in_ready=1.
REQ-039 Wrap: 20 cycles of push 2 / take 2 after priming count=2 -> pc order strictly sequential across pointer wrap, count stays 2.
REQ-040 Count=5, flush with push 11 and take 11 and stop=1 -> next cycle count=0, out_valid=00, in_ready=1.
REQ-041 Count=3, stop=1 with push 11 and take 11 for 4 cycles -> count stays 3, outputs unchanged; rst low mid-stream -> count=0 immediately.
